// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder (serial_add_unit).
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int num_digits(input int width, input int digit);
      return width / digit;
   endfunction

   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_add_unit_digit_adder.sv
// digit_adder: DIGIT-bit combinational ripple adder; c_msb is the carry into the top bit.
module digit_adder #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb
);

   always_comb begin
      logic [DIGIT:0] c;
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < DIGIT; i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
      co    = c[DIGIT];
      c_msb = c[DIGIT-1];
   end

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial adder, DIGIT bits per clock, LSD first. Define SERIAL_ADD_SUB_EN to add
// the sub port (a - b computed as a + ~b + 1).
module serial_add_unit
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic [1:0]       dbg_state
);

   localparam int N  = num_digits(WIDTH, DIGIT);
   localparam int CW = cnt_width(N);

   if (WIDTH < 2) begin : g_bad_width
      $error("serial_add_unit: WIDTH must be at least 2");
   end
   if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("serial_add_unit: DIGIT must divide WIDTH");
   end

   // Handshake: start is taken on a rising edge only in IDLE or DONE; busy is high for the
   // N RUN cycles that follow; done pulses for one cycle, after which sum/cout/overflow
   // stay stable until the next accepted start.
   state_e           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [DIGIT-1:0] d_s;
   logic             d_co;
   logic             d_cmsb;
   logic [WIDTH-1:0] b_load;
   logic             c_load;
   logic             accept;

`ifdef SERIAL_ADD_SUB_EN
   assign b_load = sub ? ~b : b;
   assign c_load = sub ? 1'b1 : cin;
`else
   assign b_load = b;
   assign c_load = cin;
`endif

   assign accept    = start && (state == IDLE || state == DONE);
   assign dbg_state = state;

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .x     (a_sr[DIGIT-1:0]),
      .y     (b_sr[DIGIT-1:0]),
      .ci    (carry),
      .s     (d_s),
      .co    (d_co),
      .c_msb (d_cmsb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_sr     <= '0;
         b_sr     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  a_sr  <= a;
                  b_sr  <= b_load;
                  carry <= c_load;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               // New digit enters at the top so the LSD lands at bit 0 after N shifts.
               sum   <= (sum >> DIGIT) | (WIDTH'(d_s) << (WIDTH - DIGIT));
               a_sr  <= a_sr >> DIGIT;
               b_sr  <= b_sr >> DIGIT;
               carry <= d_co;
               cnt   <= cnt + CW'(1);
               if (cnt == CW'(N - 1)) begin
                  cout     <= d_co;
                  overflow <= d_co ^ d_cmsb;
                  cnt      <= '0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/serial_add_unit.md
# serial_add_unit

Parametrised, clocked bit-serial adder that replaces the purely combinational 8-bit adder, trading area for latency. Operands are captured on a start pulse and summed DIGIT bits per clock, least-significant digit first, through a single carry flip-flop. Result, carry-out and signed overflow are held after a one-cycle done pulse. Sits between operand registers and any consumer that can tolerate multi-cycle arithmetic.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per clock; must divide WIDTH evenly. N = WIDTH/DIGIT is the number of compute cycles.
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, sampled on the accepting edge.
- b  input  WIDTH  operand B, sampled on the accepting edge.
- cin  input  1  carry-in, sampled on the accepting edge.
- sub  input  1  subtract select; present only when SERIAL_ADD_SUB_EN is defined.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, result valid.
- sum  output  WIDTH  result, held until the next accepted start.
- cout  output  1  final carry-out.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start=1 → load a, b into shift registers, carry flop ← cin, digit counter ← 0, go to RUN.
- RUN: each edge adds the low DIGIT bits of both shift registers plus the carry. The sum digit shifts into sum from the MSB end, operands shift right by DIGIT, the carry flop updates, and the counter increments. After the edge with counter = N-1, latch cout and overflow, go to DONE.
- DONE: done=1 for exactly one cycle. start=1 here is accepted as in IDLE (back-to-back operation). Otherwise go to IDLE.
- start is ignored while in RUN; inputs may change freely while busy.
- Arithmetic: sum = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum. Overflow uses the carry into bit WIDTH-1, taken from the final digit's internal ripple.
- sum, cout and overflow are only meaningful after done. During RUN, sum shows partial shifted data; consumers must not sample it then.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, overflow=0; state IDLE. Shift registers and counter are cleared.
- start accepted at edge E: busy=1 after edge E through edge E+N. done=1 after edge E+N until edge E+N+1.
- Latency is start-to-done N+1 edges. Throughput is one result per N+1 cycles with back-to-back starts.
- WIDTH=8, DIGIT=1: done 9 cycles after start. WIDTH=8, DIGIT=2: done 5 cycles after start.
- rst_n low mid-RUN aborts immediately. All outputs return to reset values, and no done is issued for the aborted operation.
- start held high continuously: a new operation begins in each DONE cycle.

## Configuration
- SERIAL_ADD_SUB_EN defined: the sub port exists and is sampled with the operands.
  - sub=1 computes a − b as a + ~b + 1; cin is ignored and the carry flop is loaded with 1.
  - cout=1 means no borrow. Overflow uses the same rule as addition.
- Undefined: no sub port; the block is an adder only, and ~b is never generated.

## Structure
- Package serial_add_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a localparam function for N = WIDTH/DIGIT;
  - the counter width, computed as clog2 of N, minimum 1.
- One combinational sub-module, digit_adder: a DIGIT-bit ripple adder with inputs x, y, ci and outputs s, co, and c_msb (the carry into its top bit), used for overflow.
- Elaboration-time check rejects DIGIT not dividing WIDTH.

## Test plan
- WIDTH=8, DIGIT=1: a=1, b=2, cin=0 → done 9 cycles after start; sum=3, cout=0, overflow=0.
- a=255, b=1 → sum=0, cout=1, overflow=0. Then a=127, b=1 → sum=128, cout=0, overflow=1.
- DIGIT=2: a=37, b=21, cin=1 → done after 5 cycles; sum=59. Pulse start again while busy → ignored, no extra done.
- Back-to-back: start held high with a=31, b=1 then a=0, b=0 → done pulses 9 cycles apart; sums 32 then 0.
- Drop rst_n in the 4th RUN cycle → busy, done, sum and cout go to 0 immediately, no done. A fresh start afterwards completes correctly.
- SERIAL_ADD_SUB_EN defined, sub=1: a=5, b=7 → sum=254, cout=0. a=7, b=5 → sum=2, cout=1.
